riscv_div_seq: RTL and testbench
================================

# riscv_div_seq

Sequential radix-2 divider that services the ALU's division opcodes (ALU_DIVU, ALU_DIV, ALU_REMU, ALU_REM). The EX stage issues a request over a valid/ready handshake and stalls until the divider returns a result over a second valid/ready handshake. It sits beside the ALU in the EX stage and produces one quotient bit per cycle with fixed latency.

## Interface
- WIDTH, 32, operand and result width.
- OP_WIDTH, 7, opcode width; equals ALU_OP_WIDTH.
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush_i  in  1  synchronous abort of any in-flight or pending operation.
- op_i  in  OP_WIDTH  ALU opcode; sampled on input handshake.
- opa_i  in  WIDTH  dividend; sampled on input handshake.
- opb_i  in  WIDTH  divisor; sampled on input handshake.
- in_valid_i  in  1  request valid.
- in_ready_o  out  1  divider can accept a request.
- res_o  out  WIDTH  quotient or remainder; valid while out_valid_o=1.
- out_valid_o  out  1  result valid.
- out_ready_i  in  1  consumer accepts the result.

## Operation
- Opcode decode: op_i[0] selects signed operation (1) or unsigned operation (0). op_i[1] selects remainder (1) or quotient (0). A request is a div request when op_i[6:2]=5'b01100.
- A request whose opcode is not a div request is still accepted. It returns res_o=0 after the normal latency.
- States: IDLE, CALC, DONE.
- IDLE: in_ready_o=1.
  - On in_valid_i=1 with flush_i=0, latch the operand magnitudes. In signed mode these are the absolute values, where |0x80000000| = 0x80000000 unsigned. Also latch the sign flags and the mode bits. Clear the partial remainder, load counter=WIDTH-1, and go to CALC.
- CALC: restoring step each cycle.
  - Shift {rem, dividend} left by 1.
  - If rem ≥ divisor, subtract the divisor and set quotient bit=1.
  - Compute the subtraction at WIDTH+1 bits.
  - The counter decrements each cycle. In the cycle where counter=0, go to DONE.
- DONE: out_valid_o=1 and res_o is held stable.
  - On out_ready_i=1, go to IDLE.
- Sign fixup is combinational from the DONE registers:
  - Quotient is negated iff signed mode, the operand signs differ, and the divisor is non-zero.
  - Remainder is negated iff signed mode and the dividend is negative.
- Divide by zero: quotient=all ones. Remainder=dividend, with the original sign.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0. This results naturally from the algorithm and needs no special case.
- flush_i=1 has priority over every other input. On the next edge the state is IDLE and out_valid_o=0.
  - A request presented in the same cycle as flush_i is not accepted.
- in_ready_o=0 in CALC and DONE. A new request cannot be accepted in the same cycle as the output handshake.

## Timing
- Reset values: state=IDLE, in_ready_o=1, out_valid_o=0, res_o=0, counter=0, all datapath registers=0.
- Reset asserted mid-operation discards the operation immediately. The block is in IDLE on deassertion.
- Latency: a request accepted at edge k gives out_valid_o=1 from edge k+WIDTH, i.e. k+32. Latency is the same for every operand value, including zero divisor.
- Throughput: with out_ready_i held at 1, the next request can be accepted at edge k+WIDTH+2. Back-to-back issue interval is WIDTH+2 cycles.
- Backpressure: with out_ready_i=0, DONE persists indefinitely, and res_o and out_valid_o stay constant.
- The output handshake completes on an edge with out_valid_o=1 and out_ready_i=1. out_valid_o=0 after that edge.
- op_i, opa_i and opb_i are don't-care outside the input handshake cycle.

## Test plan
- ALU_DIVU, 100 / 7 → res_o=14 at exactly edge k+32. ALU_REMU on the same operands → 2.
- ALU_DIV, -7 / 2 → 0xFFFFFFFD (-3). ALU_REM, -7 / 2 → 0xFFFFFFFF (-1). ALU_REM, 7 / -2 → 1.
- ALU_DIV, 5 / 0 → 0xFFFFFFFF. ALU_DIV, -5 / 0 → 0xFFFFFFFF. ALU_REM, -5 / 0 → 0xFFFFFFFB. ALU_DIVU, 0xFFFFFFFF / 0 → 0xFFFFFFFF.
- ALU_DIV, 0x80000000 / 0xFFFFFFFF → 0x80000000. ALU_REM on the same operands → 0. ALU_DIVU, 0x80000000 / 1 → 0x80000000.
- Backpressure: hold out_ready_i=0 for 10 cycles after out_valid_o rises → res_o stable and in_ready_o=0. Raise out_ready_i → IDLE on the next edge and in_ready_o=1.
- Flush and reset: issue ALU_DIVU 1000/3, then flush_i=1 at cycle 10 → out_valid_o never rises. Then issue 9/3 → 3 at edge k+32. Repeat the sequence with rst_n pulsed low mid-CALC → all outputs return to their reset values asynchronously.

Source files
------------

// File: rtl/riscv_div_seq.sv
// Sequential radix-2 restoring divider for DIVU/DIV/REMU/REM, one quotient bit per cycle.
// Fixed latency of WIDTH cycles from the input handshake to out_valid_o; the result is held in DONE until out_ready_i.
module riscv_div_seq #(
    parameter int WIDTH    = 32,
    parameter int OP_WIDTH = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush_i,
    input  logic [OP_WIDTH-1:0] op_i,
    input  logic [WIDTH-1:0]    opa_i,
    input  logic [WIDTH-1:0]    opb_i,
    input  logic                in_valid_i,
    output logic                in_ready_o,
    output logic [WIDTH-1:0]    res_o,
    output logic                out_valid_o,
    input  logic                out_ready_i
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic             rem_sel_q, rem_sel_d;
    logic             is_div_q, is_div_d;
    logic             neg_a_q, neg_a_d;
    logic             neg_b_q, neg_b_d;

    logic             accept;
    logic             sgn_a, sgn_b;
    logic [WIDTH:0]   shifted, diff;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign accept = (state_q == S_IDLE) && in_valid_i && !flush_i;
    assign sgn_a  = op_i[0] & opa_i[WIDTH-1];
    assign sgn_b  = op_i[0] & opb_i[WIDTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (in_valid_i) state_d = S_CALC;
                S_CALC:  if (cnt_q == '0) state_d = S_DONE;
                S_DONE:  if (out_ready_i) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready_o  = (state_q == S_IDLE);
        out_valid_o = (state_q == S_DONE);
    end

    // Subtraction at WIDTH+1 bits: the top bit is set exactly when the shifted remainder is below the divisor.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs_q};

    always_comb begin
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        rem_sel_d = rem_sel_q;
        is_div_d  = is_div_q;
        neg_a_d   = neg_a_q;
        neg_b_d   = neg_b_q;
        if (accept) begin
            cnt_d     = CW'(WIDTH - 1);
            rem_d     = '0;
            quo_d     = sgn_a ? (~opa_i + 1'b1) : opa_i;
            dvs_d     = sgn_b ? (~opb_i + 1'b1) : opb_i;
            rem_sel_d = op_i[1];
            is_div_d  = (op_i[6:2] == 5'b01100);
            neg_a_d   = sgn_a;
            neg_b_d   = sgn_b;
        end else if (state_q == S_CALC) begin
            cnt_d = cnt_q - CW'(1);
            quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
            rem_d = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            rem_sel_q <= 1'b0;
            is_div_q  <= 1'b0;
            neg_a_q   <= 1'b0;
            neg_b_q   <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            rem_sel_q <= rem_sel_d;
            is_div_q  <= is_div_d;
            neg_a_q   <= neg_a_d;
            neg_b_q   <= neg_b_d;
        end
    end

    // A zero divisor leaves the quotient as all ones and the remainder as the dividend magnitude.
    assign q_fix = ((neg_a_q ^ neg_b_q) && (dvs_q != '0)) ? (~quo_q + 1'b1) : quo_q;
    assign r_fix = neg_a_q ? (~rem_q + 1'b1) : rem_q;

    always_comb begin
        res_o = '0;
        if (state_q == S_DONE && is_div_q) begin
            res_o = rem_sel_q ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_riscv_div_seq.sv
module tb_riscv_div_seq;
    localparam logic [6:0] DIVU = 7'h30;
    localparam logic [6:0] DIV  = 7'h31;
    localparam logic [6:0] REMU = 7'h32;
    localparam logic [6:0] REM  = 7'h33;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_i = 1'b0;
    logic [6:0]  op_i = '0;
    logic [31:0] opa_i = '0;
    logic [31:0] opb_i = '0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [31:0] res_o;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;

    int total = 0;
    int bad = 0;

    riscv_div_seq #(.WIDTH(32), .OP_WIDTH(7)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i),
        .op_i(op_i), .opa_i(opa_i), .opb_i(opb_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .res_o(res_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, checks latency and result, leaves the divider in DONE with out_ready_i=0.
    task automatic issue_wait(input string tag, input logic [6:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic [31:0] exp);
        int lat;
        @(negedge clk);
        chk({tag, "_rdy"}, {31'd0, in_ready_o}, 32'd1);
        op_i = op; opa_i = a; opb_i = b; in_valid_i = 1'b1; out_ready_i = 1'b0;
        @(posedge clk); #1;
        in_valid_i = 1'b0; opa_i = 32'hDEAD_BEEF; opb_i = 32'h1234_5678;
        lat = 0;
        while (!out_valid_o && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_lat"}, lat, 32);
        chk({tag, "_res"}, res_o, exp);
    endtask

    task automatic run_op(input string tag, input logic [6:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        issue_wait(tag, op, a, b, exp);
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk({tag, "_vld_after"}, {31'd0, out_valid_o}, 32'd0);
    endtask

    initial begin
        logic [31:0] held;
        int seen;

        #12;
        chk("reset_rdy", {31'd0, in_ready_o}, 32'd1);
        chk("reset_vld", {31'd0, out_valid_o}, 32'd0);
        chk("reset_res", res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("divu_100_7", DIVU, 32'd100, 32'd7, 32'd14);
        run_op("remu_100_7", REMU, 32'd100, 32'd7, 32'd2);
        run_op("div_m7_2",   DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run_op("rem_m7_2",   REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run_op("rem_7_m2",   REM,  32'd7, 32'hFFFF_FFFE, 32'd1);
        run_op("div_5_0",    DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_op("div_m5_0",   DIV,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF);
        run_op("rem_m5_0",   REM,  32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB);
        run_op("divu_max_0", DIVU, 32'hFFFF_FFFF, 32'd0, 32'hFFFF_FFFF);
        run_op("div_ovf",    DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",    REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
        run_op("divu_min_1", DIVU, 32'h8000_0000, 32'd1, 32'h8000_0000);
        run_op("non_div_op", 7'h00, 32'd5, 32'd3, 32'd0);

        // Backpressure: DONE holds for ten cycles with out_ready_i low.
        issue_wait("bp", DIVU, 32'd100, 32'd7, 32'd14);
        held = res_o;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_res_stable", res_o, held);
            chk("bp_vld_held", {31'd0, out_valid_o}, 32'd1);
            chk("bp_rdy_low", {31'd0, in_ready_o}, 32'd0);
        end
        @(negedge clk);
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        out_ready_i = 1'b0;
        chk("bp_idle_vld", {31'd0, out_valid_o}, 32'd0);
        chk("bp_idle_rdy", {31'd0, in_ready_o}, 32'd1);

        // Flush mid-CALC, with a competing request in the flush cycle that must be dropped.
        @(negedge clk);
        op_i = DIVU; opa_i = 32'd1000; opb_i = 32'd3; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        flush_i = 1'b1; in_valid_i = 1'b1; opa_i = 32'd50; opb_i = 32'd5;
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        chk("flush_rdy", {31'd0, in_ready_o}, 32'd1);
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen++;
        end
        chk("flush_no_vld", seen, 0);
        run_op("after_flush_9_3", DIVU, 32'd9, 32'd3, 32'd3);

        // Asynchronous reset mid-CALC.
        @(negedge clk);
        op_i = DIVU; opa_i = 32'd1000; opb_i = 32'd3; in_valid_i = 1'b1;
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        chk("pre_rst_rdy", {31'd0, in_ready_o}, 32'd0);
        rst_n = 1'b0;
        #1;
        chk("arst_rdy", {31'd0, in_ready_o}, 32'd1);
        chk("arst_vld", {31'd0, out_valid_o}, 32'd0);
        chk("arst_res", res_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid_o) seen++;
        end
        chk("arst_no_vld", seen, 0);
        run_op("after_rst_9_3", DIVU, 32'd9, 32'd3, 32'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
